// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store unit.
// Data accesses have priority, fetch has a starvation guard, and hung transfers time out.
`timescale 1ns/1ps
module cpu_bus_arbiter #(
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_rdata,
  output logic        o_fetch_error,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wmask,
  output logic        o_data_ready,
  output logic [31:0] o_data_rdata,
  output logic        o_data_error,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [1:0]  o_grant
);

  localparam int BURST_W = $clog2(DATA_BURST_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W  = (TO_W > 8) ? TO_W : 8;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DATA_BURST_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } state_t;

  state_t              state_r;
  logic [BURST_W-1:0]  burst_count_r;
  logic [WAIT_W-1:0]   wait_count_r;
  logic                timeout_s;
  logic                done_s;
  logic                grant_data_s;

  // Timeout detection, completion and IDLE arbitration decision
  always_comb begin
    timeout_s    = 1'b0;
    done_s       = 1'b0;
    grant_data_s = 1'b0;
    if ((TIMEOUT_CYCLES != 0) && (state_r != IDLE) && !i_bus_ready &&
        (wait_count_r == WAIT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (state_r != IDLE) begin
      done_s = i_bus_ready | timeout_s;
    end else begin
      done_s = 1'b0;
    end
    // Fetch wins a tie only once data has used up its burst allowance
    if (i_data_request && !(i_fetch_request && (burst_count_r == BURST_MAX))) begin
      grant_data_s = 1'b1;
    end else begin
      grant_data_s = 1'b0;
    end
  end

  // Requester-side completion pulses; read data is forced to zero on a timeout
  always_comb begin
    o_fetch_ready = 1'b0;
    o_fetch_rdata = 32'd0;
    o_fetch_error = 1'b0;
    o_data_ready  = 1'b0;
    o_data_rdata  = 32'd0;
    o_data_error  = 1'b0;
    case (state_r)
      FETCH: begin
        o_fetch_ready = done_s;
        o_fetch_rdata = i_bus_ready ? i_bus_rdata : 32'd0;
        o_fetch_error = timeout_s;
      end
      DATA: begin
        o_data_ready = done_s;
        o_data_rdata = i_bus_ready ? i_bus_rdata : 32'd0;
        o_data_error = timeout_s;
      end
      default: begin
        o_fetch_ready = 1'b0;
        o_data_ready  = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with registered bus outputs, burst and wait counters
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= IDLE;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= 32'd0;
      o_bus_wdata   <= 32'd0;
      o_bus_wmask   <= 4'd0;
      o_grant       <= 2'b00;
      burst_count_r <= '0;
      wait_count_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_count_r <= '0;
          if (grant_data_s) begin
            state_r       <= DATA;
            o_bus_request <= 1'b1;
            o_bus_rw      <= i_data_rw;
            o_bus_address <= i_data_address;
            o_bus_wdata   <= i_data_wdata;
            o_bus_wmask   <= i_data_rw ? i_data_wmask : 4'd0;
            o_grant       <= 2'b10;
          end else if (i_fetch_request) begin
            state_r       <= FETCH;
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= i_fetch_address;
            o_bus_wdata   <= 32'd0;
            o_bus_wmask   <= 4'd0;
            o_grant       <= 2'b01;
          end
          if (!i_fetch_request) begin
            burst_count_r <= '0;
          end else if (grant_data_s) begin
            if (burst_count_r != BURST_MAX) burst_count_r <= burst_count_r + BURST_W'(1);
          end else begin
            burst_count_r <= '0;
          end
        end
        FETCH, DATA: begin
          if (done_s) begin
            state_r       <= IDLE;
            o_bus_request <= 1'b0;
            o_grant       <= 2'b00;
            wait_count_r  <= '0;
          end else if (wait_count_r != {WAIT_W{1'b1}}) begin
            wait_count_r <= wait_count_r + WAIT_W'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          o_bus_request <= 1'b0;
          o_grant       <= 2'b00;
          wait_count_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: priority, starvation guard, timeout and async reset.
`timescale 1ns/1ps
module tb_cpu_bus_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_fetch_request;
  logic [31:0] i_fetch_address;
  logic        o_fetch_ready;
  logic [31:0] o_fetch_rdata;
  logic        o_fetch_error;
  logic        i_data_request;
  logic        i_data_rw;
  logic [31:0] i_data_address;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_wmask;
  logic        o_data_ready;
  logic [31:0] o_data_rdata;
  logic        o_data_error;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [1:0]  o_grant;

  int checks = 0;
  int fails  = 0;

  cpu_bus_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_fetch_request(i_fetch_request), .i_fetch_address(i_fetch_address),
    .o_fetch_ready(o_fetch_ready), .o_fetch_rdata(o_fetch_rdata), .o_fetch_error(o_fetch_error),
    .i_data_request(i_data_request), .i_data_rw(i_data_rw), .i_data_address(i_data_address),
    .i_data_wdata(i_data_wdata), .i_data_wmask(i_data_wmask),
    .o_data_ready(o_data_ready), .o_data_rdata(o_data_rdata), .o_data_error(o_data_error),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata), .o_grant(o_grant)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_grant;
    i_reset = 1'b0;
    i_fetch_request = 1'b0; i_fetch_address = 32'd0;
    i_data_request = 1'b0; i_data_rw = 1'b0; i_data_address = 32'd0;
    i_data_wdata = 32'd0; i_data_wmask = 4'd0;
    i_bus_ready = 1'b0; i_bus_rdata = 32'd0;
    tick(); tick();
    check("rst_bus_request", {31'd0, o_bus_request}, 32'd0);
    check("rst_grant", {30'd0, o_grant}, 32'd0);
    check("rst_bus_address", o_bus_address, 32'd0);
    i_reset = 1'b1;
    tick();

    // Fetch only, bus ready in the third grant cycle
    i_fetch_request = 1'b1; i_fetch_address = 32'h100;
    tick();
    check("f_bus_request", {31'd0, o_bus_request}, 32'd1);
    check("f_bus_address", o_bus_address, 32'h100);
    check("f_bus_rw", {31'd0, o_bus_rw}, 32'd0);
    check("f_bus_wmask", {28'd0, o_bus_wmask}, 32'd0);
    check("f_grant", {30'd0, o_grant}, 32'd1);
    check("f_ready_early", {31'd0, o_fetch_ready}, 32'd0);
    tick(); tick();
    i_bus_ready = 1'b1; i_bus_rdata = 32'h00000013;
    #1;
    check("f_ready", {31'd0, o_fetch_ready}, 32'd1);
    check("f_rdata", o_fetch_rdata, 32'h13);
    check("f_error", {31'd0, o_fetch_error}, 32'd0);
    check("f_data_ready", {31'd0, o_data_ready}, 32'd0);
    tick();
    i_fetch_request = 1'b0; i_bus_ready = 1'b0;
    check("f_bus_request_after", {31'd0, o_bus_request}, 32'd0);
    check("f_ready_after", {31'd0, o_fetch_ready}, 32'd0);
    tick();

    // Simultaneous fetch and data write: data first
    i_fetch_request = 1'b1; i_fetch_address = 32'h300;
    i_data_request = 1'b1; i_data_rw = 1'b1; i_data_address = 32'h2000;
    i_data_wdata = 32'hDEADBEEF; i_data_wmask = 4'hF;
    tick();
    check("s_grant_data", {30'd0, o_grant}, 32'd2);
    check("s_bus_rw", {31'd0, o_bus_rw}, 32'd1);
    check("s_bus_address", o_bus_address, 32'h2000);
    check("s_bus_wdata", o_bus_wdata, 32'hDEADBEEF);
    check("s_bus_wmask", {28'd0, o_bus_wmask}, 32'hF);
    i_bus_ready = 1'b1; i_bus_rdata = 32'd0;
    #1;
    check("s_data_ready", {31'd0, o_data_ready}, 32'd1);
    check("s_fetch_ready_blocked", {31'd0, o_fetch_ready}, 32'd0);
    tick();
    i_data_request = 1'b0; i_data_rw = 1'b0; i_bus_ready = 1'b0;
    check("s_idle_gap", {31'd0, o_bus_request}, 32'd0);
    tick();
    check("s_grant_fetch", {30'd0, o_grant}, 32'd1);
    check("s_fetch_address", o_bus_address, 32'h300);
    check("s_fetch_wmask", {28'd0, o_bus_wmask}, 32'd0);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h0000ABCD;
    #1;
    check("s_fetch_rdata", o_fetch_rdata, 32'h0000ABCD);
    check("s_data_rdata_zero", o_data_rdata, 32'd0);
    tick();
    i_fetch_request = 1'b0; i_bus_ready = 1'b0;
    tick();

    // Starvation guard: four data grants, one fetch, then data again
    i_fetch_request = 1'b1; i_fetch_address = 32'h400;
    i_data_request = 1'b1; i_data_rw = 1'b0; i_data_address = 32'h500;
    for (int g = 1; g <= 6; g++) begin
      exp_grant = (g == 5) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("b_grant_%0d", g), {30'd0, o_grant}, {30'd0, exp_grant});
      check($sformatf("b_addr_%0d", g), o_bus_address, (g == 5) ? 32'h400 : 32'h500);
      i_bus_ready = 1'b1; i_bus_rdata = 32'd0;
      #1;
      tick();
      i_bus_ready = 1'b0;
      if (g == 5) i_fetch_request = 1'b0;
    end
    i_data_request = 1'b0;
    tick();

    // Timeout: bus never ready, pulse in the 8th grant cycle
    i_data_request = 1'b1; i_data_rw = 1'b0; i_data_address = 32'h600;
    i_bus_rdata = 32'hFFFFFFFF;
    tick();
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t_no_ready_%0d", c), {31'd0, o_data_ready}, 32'd0);
      tick();
    end
    check("t_ready", {31'd0, o_data_ready}, 32'd1);
    check("t_error", {31'd0, o_data_error}, 32'd1);
    check("t_rdata_zero", o_data_rdata, 32'd0);
    tick();
    i_data_request = 1'b0;
    check("t_bus_request_after", {31'd0, o_bus_request}, 32'd0);
    check("t_grant_after", {30'd0, o_grant}, 32'd0);
    i_bus_ready = 1'b1;
    #1;
    check("t_late_ready", {31'd0, o_data_ready}, 32'd0);
    check("t_late_error", {31'd0, o_data_error}, 32'd0);
    tick();
    check("t_late_no_grant", {30'd0, o_grant}, 32'd0);
    i_bus_ready = 1'b0;
    tick();

    // Ready lands on the timeout cycle: ready wins, no error
    i_data_request = 1'b1; i_data_address = 32'h700;
    tick();
    for (int c = 1; c <= 7; c++) tick();
    i_bus_ready = 1'b1; i_bus_rdata = 32'h55;
    #1;
    check("c_ready", {31'd0, o_data_ready}, 32'd1);
    check("c_error", {31'd0, o_data_error}, 32'd0);
    check("c_rdata", o_data_rdata, 32'h55);
    tick();
    i_data_request = 1'b0; i_bus_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of a data grant
    i_data_request = 1'b1; i_data_rw = 1'b1; i_data_address = 32'h800;
    i_data_wdata = 32'h12345678; i_data_wmask = 4'h3;
    tick();
    check("r_granted", {31'd0, o_bus_request}, 32'd1);
    tick();
    #2;
    i_reset = 1'b0;
    #1;
    check("r_bus_request", {31'd0, o_bus_request}, 32'd0);
    check("r_grant", {30'd0, o_grant}, 32'd0);
    check("r_bus_address", o_bus_address, 32'd0);
    check("r_bus_wmask", {28'd0, o_bus_wmask}, 32'd0);
    i_bus_ready = 1'b1;
    #1;
    check("r_stray_ready", {31'd0, o_data_ready}, 32'd0);
    i_bus_ready = 1'b0;
    tick();
    i_reset = 1'b1;
    #1;
    check("r_no_grant_yet", {31'd0, o_bus_request}, 32'd0);
    tick();
    check("r_regrant", {31'd0, o_bus_request}, 32'd1);
    check("r_regrant_wdata", o_bus_wdata, 32'h12345678);
    check("r_regrant_wmask", {28'd0, o_bus_wmask}, 32'h3);
    i_bus_ready = 1'b1;
    #1;
    check("r_regrant_ready", {31'd0, o_data_ready}, 32'd1);
    tick();
    i_data_request = 1'b0; i_bus_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Two-port bus arbiter that shares the CPU's single memory bus between the instruction fetch unit and the load/store (data) unit. It sits between the pipeline and the memory/peripheral interconnect. It uses the same request/ready handshake on all three sides. It gives data accesses priority with a starvation guard for fetch, and it terminates hung transfers with a timeout error.

## Interface
Parameters:
- DATA_BURST_MAX, 4, max consecutive data grants while fetch is pending before fetch is forced a grant (≥1)
- TIMEOUT_CYCLES, 255, bus wait cycles before abort; 0 disables timeout

Ports:
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_fetch_request  in  1  fetch requests a read; held until o_fetch_ready
- i_fetch_address  in  32  fetch address, stable while request high
- o_fetch_ready  out  1  one-cycle completion pulse to fetch
- o_fetch_rdata  out  32  read data, valid with o_fetch_ready
- o_fetch_error  out  1  timeout flag, valid with o_fetch_ready
- i_data_request  in  1  data unit requests an access; held until o_data_ready
- i_data_rw  in  1  1 = write, 0 = read
- i_data_address  in  32  data address
- i_data_wdata  in  32  write data
- i_data_wmask  in  4  byte enables for writes
- o_data_ready  out  1  one-cycle completion pulse to data unit
- o_data_rdata  out  32  read data, valid with o_data_ready
- o_data_error  out  1  timeout flag, valid with o_data_ready
- o_bus_request  out  1  registered bus request
- o_bus_rw  out  1  registered; 0 for fetch grants
- o_bus_address  out  32  registered address
- o_bus_wdata  out  32  registered write data
- o_bus_wmask  out  4  registered mask; 0 for reads
- i_bus_ready  in  1  bus completion pulse
- i_bus_rdata  in  32  bus read data
- o_grant  out  2  00 idle, 01 fetch, 10 data (registered)

## Operation
- States: IDLE, FETCH, DATA.
- IDLE:
  - Only data pending → DATA.
  - Only fetch pending → FETCH.
  - Both pending → DATA, unless burst_count == DATA_BURST_MAX, in which case → FETCH.
  - On entering a grant state, latch the granted requester's address, rw, wdata and wmask into the bus registers, and set o_bus_request=1.
- FETCH/DATA: o_<granted>_ready = i_bus_ready, combinational. rdata passes through from i_bus_rdata. Non-granted ready, rdata and error stay at 0.
- Completion when i_bus_ready=1 in a grant state:
  - o_bus_request←0 and state←IDLE at that edge.
  - The wait counter clears.
- Timeout (TIMEOUT_CYCLES≠0) when wait counter == TIMEOUT_CYCLES−1 and i_bus_ready=0:
  - Assert o_<granted>_ready=1 and o_<granted>_error=1 that cycle, with rdata=0.
  - Then behave as completion.
- i_bus_ready and timeout in the same cycle: ready wins and error=0.
- i_bus_ready in IDLE (late or stray): ignored.
- burst_count (width clog2(DATA_BURST_MAX+1)):
  - +1 on each data grant while fetch is pending, saturating.
  - Cleared on a fetch grant, or in any IDLE cycle with i_fetch_request=0.
- The wait counter is 8 bits or wider, sized to TIMEOUT_CYCLES. It increments each grant-state cycle without i_bus_ready, saturates, and clears in IDLE.
- Requester obligation: drop the request on the edge following its ready pulse. The arbiter re-samples requests only in IDLE, so a request held one extra cycle is re-granted as a new transfer.

## Timing
- Reset (asynchronous assert, any state, including mid-transfer):
  - state=IDLE.
  - o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_bus_wmask=0.
  - o_grant=0, all counters 0.
  - Combinational outputs therefore 0.
  - An abandoned bus transfer's later ready is ignored.
- Grant latency: request high at edge k in IDLE → o_bus_request=1 from cycle k+1.
- Completion: requester ready equals i_bus_ready in the same cycle (zero latency). o_bus_request is low the next cycle.
- Back-to-back: after completion at edge m, IDLE samples at edge m+1. The next o_bus_request rises at m+2, so there is at least one idle bus cycle between transfers.
- Bus outputs are stable for the whole grant. Requester input changes during a grant are not propagated.

## Test plan
- Fetch only: fetch request at 0x100, bus ready after 3 cycles with 0x00000013 → o_bus_address=0x100, rw=0, wmask=0; o_fetch_ready pulses once with rdata 0x13; o_bus_request low next cycle.
- Simultaneous: fetch and data write (0x2000, 0xDEADBEEF, mask 0xF) raised the same cycle → data granted first with the correct wdata and mask; fetch granted after data completes.
- Starvation: data requests continuously while fetch is held, DATA_BURST_MAX=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Timeout, TIMEOUT_CYCLES=8, bus never ready → o_data_ready and o_data_error pulse in the 8th grant cycle with rdata=0. A late i_bus_ready in IDLE causes no pulse.
- Ready coincides with the timeout cycle → ready=1 and error=0.
- Reset low mid-DATA grant → o_bus_request=0 and o_grant=0 immediately (asynchronous). After release, the first grant follows the normal 1-cycle latency.
